// File: rtl/sr_mc_control.sv
// Multi-cycle control unit for schoolRISCV: sequences fetch/decode/execute/memory/writeback
// with stall-tolerant memory handshakes and a sticky trap for illegal opcodes or bus timeouts.
//
// state  | meaning
// FETCH  | instruction request outstanding, IR loads on imAck
// DECODE | classify the instruction held in the IR
// EXEC   | ALU/branch/jump completes here; loads/stores form their address
// MEM    | data request outstanding until dmAck
// WB     | load data written to the register file
// TRAP   | sticky halt, left only through rst
module sr_mc_control #(
    parameter int WAIT_MAX = 16,
    parameter bit MEM_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] cmdOp,
    input  logic [2:0] cmdF3,
    input  logic [6:0] cmdF7,
    input  logic       aluZero,
    input  logic       imAck,
    input  logic       dmAck,
    output logic       imReq,
    output logic       irWe,
    output logic       dmReq,
    output logic       dmWe,
    output logic [1:0] dmSize,
    output logic       dmSign,
    output logic       pcWe,
    output logic       pcSrc,
    output logic       regWrite,
    output logic       aluSrc,
    output logic [2:0] immSel,
    output logic [1:0] wdSrc,
    output logic [3:0] aluControl,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trapCause
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [2:0] {K_ILL, K_R, K_I, K_LUI, K_BR, K_JAL, K_LD, K_ST} kind_t;

    state_t        state, state_nxt;
    kind_t         kind;
    logic [3:0]    alu_op;
    logic          cond_zero;
    logic [1:0]    cause_q, cause_nxt;
    logic [CW-1:0] cnt;
    logic          waiting;
    logic          timeout;

    always_comb begin
        kind      = K_ILL;
        alu_op    = ALU_ADD;
        cond_zero = 1'b0;
        casez ({cmdF7, cmdF3, cmdOp})
            17'b0000000_000_0110011: begin kind = K_R; alu_op = ALU_ADD;  end
            17'b0100000_000_0110011: begin kind = K_R; alu_op = ALU_SUB;  end
            17'b0000000_001_0110011: begin kind = K_R; alu_op = ALU_SLL;  end
            17'b0000000_010_0110011: begin kind = K_R; alu_op = ALU_SLT;  end
            17'b0000000_011_0110011: begin kind = K_R; alu_op = ALU_SLTU; end
            17'b0000000_100_0110011: begin kind = K_R; alu_op = ALU_XOR;  end
            17'b0000000_101_0110011: begin kind = K_R; alu_op = ALU_SRL;  end
            17'b0100000_101_0110011: begin kind = K_R; alu_op = ALU_SRA;  end
            17'b0000000_110_0110011: begin kind = K_R; alu_op = ALU_OR;   end
            17'b0000000_111_0110011: begin kind = K_R; alu_op = ALU_AND;  end
            17'b???????_000_0010011: begin kind = K_I; alu_op = ALU_ADD;  end
            17'b0000000_001_0010011: begin kind = K_I; alu_op = ALU_SLL;  end
            17'b???????_010_0010011: begin kind = K_I; alu_op = ALU_SLT;  end
            17'b???????_011_0010011: begin kind = K_I; alu_op = ALU_SLTU; end
            17'b???????_100_0010011: begin kind = K_I; alu_op = ALU_XOR;  end
            17'b0000000_101_0010011: begin kind = K_I; alu_op = ALU_SRL;  end
            17'b0100000_101_0010011: begin kind = K_I; alu_op = ALU_SRA;  end
            17'b???????_110_0010011: begin kind = K_I; alu_op = ALU_OR;   end
            17'b???????_111_0010011: begin kind = K_I; alu_op = ALU_AND;  end
            17'b???????_???_0110111: kind = K_LUI;
            17'b???????_000_1100011: begin kind = K_BR; alu_op = ALU_SUB;  cond_zero = 1'b1; end
            17'b???????_001_1100011: begin kind = K_BR; alu_op = ALU_SUB;  cond_zero = 1'b0; end
            17'b???????_100_1100011: begin kind = K_BR; alu_op = ALU_SLT;  cond_zero = 1'b0; end
            17'b???????_101_1100011: begin kind = K_BR; alu_op = ALU_SLT;  cond_zero = 1'b1; end
            17'b???????_110_1100011: begin kind = K_BR; alu_op = ALU_SLTU; cond_zero = 1'b0; end
            17'b???????_111_1100011: begin kind = K_BR; alu_op = ALU_SLTU; cond_zero = 1'b1; end
            17'b???????_???_1101111: kind = K_JAL;
            17'b???????_000_0000011,
            17'b???????_001_0000011,
            17'b???????_010_0000011,
            17'b???????_100_0000011,
            17'b???????_101_0000011: kind = K_LD;
            17'b???????_000_0100011,
            17'b???????_001_0100011,
            17'b???????_010_0100011: kind = K_ST;
            default: kind = K_ILL;
        endcase
    end

    assign waiting = ((state == FETCH) && !imAck) || ((state == MEM) && !dmAck);
    assign timeout = (WAIT_MAX != 0) && (cnt == WAIT_LIM);

    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause_q;
        imReq      = 1'b0;
        irWe       = 1'b0;
        dmReq      = 1'b0;
        dmWe       = 1'b0;
        dmSize     = 2'd0;
        dmSign     = 1'b0;
        pcWe       = 1'b0;
        pcSrc      = 1'b0;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        immSel     = 3'd0;
        wdSrc      = 2'd0;
        aluControl = ALU_ADD;
        retire     = 1'b0;
        trap       = 1'b0;
        trapCause  = cause_q;
        case (state)
            FETCH: begin
                imReq = 1'b1;
                if (imAck) begin
                    irWe      = 1'b1;
                    state_nxt = DECODE;
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'd2;
                end
            end
            DECODE: begin
                if (kind == K_ILL || (!MEM_EN && (kind == K_LD || kind == K_ST))) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'd1;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                aluControl = alu_op;
                state_nxt  = FETCH;
                case (kind)
                    K_R: begin
                        regWrite = 1'b1;
                        pcWe     = 1'b1;
                    end
                    K_I: begin
                        regWrite = 1'b1;
                        pcWe     = 1'b1;
                        aluSrc   = 1'b1;
                    end
                    K_LUI: begin
                        regWrite = 1'b1;
                        pcWe     = 1'b1;
                        wdSrc    = 2'd1;
                        immSel   = 3'd3;
                    end
                    K_BR: begin
                        pcWe   = 1'b1;
                        immSel = 3'd2;
                        pcSrc  = (aluZero == cond_zero);
                    end
                    K_JAL: begin
                        regWrite = 1'b1;
                        wdSrc    = 2'd3;
                        immSel   = 3'd4;
                        pcWe     = 1'b1;
                        pcSrc    = 1'b1;
                    end
                    K_LD: begin
                        aluSrc    = 1'b1;
                        state_nxt = MEM;
                    end
                    K_ST: begin
                        aluSrc    = 1'b1;
                        immSel    = 3'd1;
                        state_nxt = MEM;
                    end
                    default: state_nxt = TRAP;
                endcase
            end
            MEM: begin
                dmReq  = 1'b1;
                dmWe   = (kind == K_ST);
                dmSize = cmdF3[1:0];
                dmSign = ~cmdF3[2];
                if (dmAck) begin
                    if (kind == K_ST) begin
                        pcWe      = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'd2;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                wdSrc     = 2'd2;
                pcWe      = 1'b1;
                state_nxt = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_nxt = FETCH;
        endcase
        retire = pcWe && (state != TRAP);
        // Reset silences every output, abandoning any request in flight.
        if (rst) begin
            imReq      = 1'b0;
            irWe       = 1'b0;
            dmReq      = 1'b0;
            dmWe       = 1'b0;
            dmSize     = 2'd0;
            dmSign     = 1'b0;
            pcWe       = 1'b0;
            pcSrc      = 1'b0;
            regWrite   = 1'b0;
            aluSrc     = 1'b0;
            immSel     = 3'd0;
            wdSrc      = 2'd0;
            aluControl = ALU_ADD;
            retire     = 1'b0;
            trap       = 1'b0;
            trapCause  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            cnt     <= '0;
            cause_q <= 2'd0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (waiting && (WAIT_MAX != 0))
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: doc/sr_mc_control.md
# sr_mc_control

Multi-cycle control unit for the schoolRISCV core, successor to the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with instruction and data memories that may stall. It covers the full RV32I load/store and branch sets and adds JAL. It reports illegal instructions and memory timeouts through a sticky trap state. It sits between the instruction register/datapath and the two memory ports.

## Interface
- `WAIT_MAX`, default 16: cycles a memory request may stay unacknowledged before a bus trap; 0 disables the timeout.
- `MEM_EN`, default 1: 1 decodes loads/stores; 0 treats them as illegal.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmdOp` in 7, `cmdF3` in 3, `cmdF7` in 7: fields of the instruction register.
- `aluZero` in 1: ALU result == 0.
- `imAck` in 1, `dmAck` in 1: memory acknowledges; data is valid in the ack cycle.
- `imReq` out 1, `irWe` out 1: instruction fetch request; instruction register load strobe.
- `dmReq` out 1, `dmWe` out 1: data request; write qualifier.
- `dmSize` out 2: 0 byte, 1 half, 2 word.
- `dmSign` out 1: sign-extend the load.
- `pcWe` out 1, `pcSrc` out 1: PC update strobe; PC source, 1 = pcBranch/jump target, 0 = pcPlus4.
- `regWrite` out 1, `aluSrc` out 1: register file write enable; ALU operand B, 1 = imm, 0 = rd2.
- `immSel` out 3: 0 I, 1 S, 2 B, 3 U, 4 J.
- `wdSrc` out 2: writeback source, 0 aluResult, 1 immU, 2 dmDataR, 3 pcPlus4.
- `aluControl` out 4: uses the existing `ALU_*` encodings.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `trap` out 1, `trapCause` out 2: sticky trap flag; cause 0 none, 1 illegal, 2 bus timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset enters FETCH.
- **FETCH**
  - `imReq`=1.
  - On `imAck`: `irWe`=1 and go to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - One cycle. Classifies `{cmdF7,cmdF3,cmdOp}` with casez.
  - Unmatched encoding → TRAP with cause 1.
  - With `MEM_EN`=0, loads/stores → TRAP with cause 1.
  - Otherwise → EXEC.
- **EXEC, R/I-ALU, LUI**
  - `regWrite`=1 and `pcWe`=1 with `pcSrc`=0; → FETCH.
  - R-type: `aluSrc`=0. I-ALU: `aluSrc`=1, `immSel`=I.
  - ALU ops: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU and their immediate forms.
  - SLLI/SRLI/SRAI require `cmdF7` 0000000 (SLLI, SRLI) or 0100000 (SRAI); any other `cmdF7` is illegal.
  - LUI: `wdSrc`=1.
- **EXEC, branches**
  - `pcWe`=1, `immSel`=B, `pcSrc` = `aluZero`==condZero; → FETCH.
  - BEQ: SUB, condZero 1. BNE: SUB, condZero 0.
  - BLT: SLT, condZero 0. BGE: SLT, condZero 1.
  - BLTU: SLTU, condZero 0. BGEU: SLTU, condZero 1.
- **EXEC, JAL**
  - `regWrite`=1, `wdSrc`=3, `immSel`=J, `pcWe`=1, `pcSrc`=1; → FETCH.
- **EXEC, load/store**
  - ALU ADD, `aluSrc`=1; `immSel`=I for loads, S for stores. → MEM.
- **MEM**
  - `dmReq`=1. `dmWe`=1 only for stores.
  - `dmSize` from `cmdF3[1:0]`; `dmSign` = ~`cmdF3[2]`.
  - On `dmAck`: a store asserts `pcWe` with `pcSrc`=0 and goes to FETCH; a load goes to WB.
- **WB**
  - `regWrite`=1, `wdSrc`=2, `pcWe`=1 with `pcSrc`=0; → FETCH.
- `retire` = `pcWe` and not in TRAP.
- **Timeout**
  - Counter is `$clog2(WAIT_MAX+1)` bits.
  - Clears on every state change. Increments each FETCH or MEM cycle with no ack.
  - Ack in the same cycle the counter equals `WAIT_MAX`: ack wins.
  - Counter == `WAIT_MAX` with no ack → TRAP with cause 2.
- **TRAP**
  - All strobes and requests are 0; `trap`=1.
  - Only `rst` exits TRAP.
- Unlisted outputs default to 0; `aluControl` defaults to ADD.
- Ack inputs are ignored in any state that does not assert the matching request.

## Timing
- Reset values: state FETCH, counter 0, `trapCause` 0. Every output is 0 during `rst`, including `imReq`.
- `imReq` rises in the first cycle after `rst` is released.
- Reset mid-operation abandons any pending request: `dmReq`/`dmWe` drop in the reset cycle and no `pcWe` fires.
- Outputs are combinational from the registered state and the instruction fields. No output depends on an ack except `irWe`, the store `pcWe` and `retire`.
- Requests stay high and stable until acked. There is no re-issue and no abort.
- Latency with zero-wait acks:
  - ALU/LUI/branch/JAL: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds 1 cycle.

## Test plan
- ADD x3,x1,x2, imAck same cycle → `irWe` cycle 0, `regWrite`+`pcWe`+`retire` in cycle 2, `aluControl`=ALU_ADD, `pcSrc`=0.
- BGE with `aluZero`=1 → `aluControl`=ALU_SLT, `pcSrc`=1. With `aluZero`=0 → `pcSrc`=0. Check all six branch types both ways.
- LBU, dmAck delayed 3 cycles → `dmReq` held 4 cycles, `dmSize`=0, `dmSign`=0, then a WB cycle with `wdSrc`=2 and `regWrite`=1; total 8 cycles.
- SW with `WAIT_MAX`=4, dmAck never → TRAP after 4 unacked MEM cycles, `trapCause`=2, `dmReq` drops. Repeat with dmAck on the 4th cycle → no trap.
- Opcode 0x7F, or SRAI with `cmdF7`=0x01 → TRAP, `trapCause`=1, no `regWrite`/`pcWe`. `rst` pulse → FETCH and `trap`=0.
- `rst` asserted during MEM of a store → `dmReq`/`dmWe` 0 in that cycle; FETCH with `imReq`=1 the cycle after release.
